bsg_fifo_1r1w_small_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one bsg_fifo_1r1w_small_hardened write port among num_req_p requesters.

---
 rtl/bsg_fifo_rr_sched_pkg.sv | 18 +
 rtl/bsg_rr_pick.sv | 30 +++
 rtl/bsg_fifo_1r1w_small_rr_sched.sv | 165 ++++++++++++++++
 tb/tb_bsg_fifo_1r1w_small_rr_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_rr_sched_pkg.sv
// rtl/bsg_fifo_rr_sched_pkg.sv - shared types and width helpers for the round-robin FIFO write scheduler
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

// Tagged FIFO entry; a macro because a package cannot carry the per-instance widths.
`ifndef BSG_RR_SCHED_ENTRY_T
`define BSG_RR_SCHED_ENTRY_T(id_w, width) struct packed { logic [(id_w)-1:0] id; logic [(width)-1:0] data; }
`endif

package bsg_fifo_rr_sched_pkg;

  typedef enum logic [0:0] {
    e_idle  = 1'b0,
    e_burst = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bsg_rr_pick.sv
// rtl/bsg_rr_pick.sv - first eligible requester at or after the round-robin pointer
module bsg_rr_pick #(
  parameter int num_req_p = 4,
  parameter int id_w      = `BSG_SAFE_CLOG2(num_req_p)
) (
  input  logic [num_req_p-1:0] eligible_i,
  input  logic [id_w-1:0]      ptr_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [id_w-1:0]      id_o,
  output logic                 v_o
);

  logic [id_w-1:0] idx;

  always_comb begin
    idx     = '0;
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = id_w'((int'(ptr_i) + k) % num_req_p);
      if (!v_o && eligible_i[idx]) begin
        v_o  = 1'b1;
        id_o = idx;
      end
    end
    grant_o[id_o] = v_o;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small_rr_sched.sv
// rtl/bsg_fifo_1r1w_small_rr_sched.sv - round-robin, quota-limited, burst-bounded write scheduler in front of one FIFO
module bsg_fifo_1r1w_small_rr_sched
  import bsg_fifo_rr_sched_pkg::*;
#(
  parameter int num_req_p   = 4,
  parameter int width_p     = 16,
  parameter int els_p       = 4,
  parameter int max_burst_p = 2,
  parameter int quota_p     = 2,
  localparam int id_w       = `BSG_SAFE_CLOG2(num_req_p),
  localparam int occ_w      = $clog2(quota_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]         req_ready_o,
  output logic                         fifo_v_o,
  output logic [id_w+width_p-1:0]      fifo_data_o,
  input  logic                         fifo_ready_param_i,
  input  logic                         fifo_deq_i,
  input  logic [id_w-1:0]              fifo_deq_id_i,
  output logic [id_w-1:0]              grant_id_o,
  output logic                         busy_o
);

  localparam int beats_w = $clog2(max_burst_p + 1);
  localparam logic [occ_w-1:0]   quota_lp     = occ_w'(quota_p);
  localparam logic [beats_w-1:0] max_burst_lp = beats_w'(max_burst_p);
  localparam logic [id_w-1:0]    last_id_lp   = id_w'(num_req_p - 1);

  typedef `BSG_RR_SCHED_ENTRY_T(id_w, width_p) entry_t;

  sched_state_e         state_q, state_d;
  logic [id_w-1:0]      ptr_q, ptr_d, owner_q, owner_d;
  logic [beats_w-1:0]   beats_q, beats_d;
  logic [occ_w-1:0]     occ_q [num_req_p];
  logic [occ_w-1:0]     occ_d [num_req_p];

  logic [num_req_p-1:0] eligible, pick_grant, owner_oh, win_oh;
  logic [id_w-1:0]      pick_id, win_id;
  logic                 pick_v, win_v, enq;
  entry_t               entry;

  function automatic logic [id_w-1:0] next_id(input logic [id_w-1:0] id);
    return (id == last_id_lp) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++) begin
      eligible[i] = req_v_i[i] && (occ_q[i] < quota_lp);
    end
  end

  bsg_rr_pick #(.num_req_p(num_req_p), .id_w(id_w)) pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .id_o       (pick_id),
    .v_o        (pick_v)
  );

  // During a burst the owner is the only candidate; the picker is ignored.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    if (state_q == e_burst) begin
      win_v  = eligible[owner_q];
      win_id = owner_q;
      win_oh = owner_oh & eligible;
    end else begin
      win_v  = pick_v;
      win_id = pick_id;
      win_oh = pick_grant;
    end
    enq = reset_n_i && fifo_ready_param_i && win_v;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beats_d = beats_q;
    case (state_q)
      e_idle: begin
        if (enq) begin
          if (max_burst_p == 1) begin
            ptr_d = next_id(win_id);
          end else begin
            owner_d = win_id;
            beats_d = beats_w'(1);
            state_d = e_burst;
          end
        end
      end
      e_burst: begin
        // A ready FIFO with an idle owner ends the burst without granting anyone this cycle.
        if (fifo_ready_param_i) begin
          if (win_v && (beats_q + 1'b1 != max_burst_lp)) begin
            beats_d = beats_q + 1'b1;
          end else begin
            beats_d = '0;
            ptr_d   = next_id(owner_q);
            state_d = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      occ_d[i] = occ_q[i];
      if (req_ready_o[i] && !(fifo_deq_i && fifo_deq_id_i == id_w'(i))) begin
        occ_d[i] = occ_q[i] + 1'b1;
      end else if (!req_ready_o[i] && fifo_deq_i && fifo_deq_id_i == id_w'(i)) begin
        occ_d[i] = occ_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      ptr_q   <= '0;
      owner_q <= '0;
      beats_q <= '0;
      for (int i = 0; i < num_req_p; i++) occ_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    entry.id    = enq ? win_id : '0;
    entry.data  = enq ? req_data_i[int'(win_id)*width_p +: width_p] : '0;
    fifo_data_o = entry;
    fifo_v_o    = enq;
    req_ready_o = enq ? win_oh : '0;
    grant_id_o  = entry.id;
    busy_o      = (state_q == e_burst);
  end

`ifndef SYNTHESIS
  int occ_sum;
  always_comb begin
    occ_sum = 0;
    for (int i = 0; i < num_req_p; i++) occ_sum = occ_sum + int'(occ_q[i]);
  end

  a_deq_occ: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fifo_deq_i |-> (occ_q[fifo_deq_id_i] != '0));
  a_occ_sum: assert property (@(posedge clk_i) disable iff (!reset_n_i) occ_sum <= els_p);
  a_ready_oh: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(req_ready_o));
  a_v_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fifo_v_o |-> fifo_ready_param_i);
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_rr_sched.sv
// tb/tb_bsg_fifo_1r1w_small_rr_sched.sv - scoreboard bench for the round-robin FIFO write scheduler
module tb_bsg_fifo_1r1w_small_rr_sched;

  localparam int N = 4, W = 16, ELS = 4, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic [N-1:0]       req_v, req_ready, acc_last;
  logic [W-1:0]       req_data [N];
  logic [N*W-1:0]     req_data_flat;
  logic               fifo_v, fifo_ready, fifo_deq, busy;
  logic [IDW+W-1:0]   fifo_data, push_val;
  logic [IDW-1:0]     fifo_deq_id, grant_id, head_id, mon_id;
  logic               rdy_en, deq_en, rand_mode, push_pend, pop_pend;
  logic [IDW+W-1:0]   fifo_m [$];
  logic [IDW+W:0]     exp_q [$];
  logic [IDW+W:0]     exp_e;
  int                 occ_m [N];
  int                 count_m, checks, failures, n_enq, base;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign req_data_flat[g*W +: W] = req_data[g];
  end

  assign fifo_ready  = rdy_en && (count_m < ELS);
  assign fifo_deq    = reset_n && deq_en && (count_m > 0);
  assign fifo_deq_id = head_id;

  bsg_fifo_1r1w_small_rr_sched #(
    .num_req_p(N), .width_p(W), .els_p(ELS), .max_burst_p(2), .quota_p(2)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .req_v_i            (req_v),
    .req_data_i         (req_data_flat),
    .req_ready_o        (req_ready),
    .fifo_v_o           (fifo_v),
    .fifo_data_o        (fifo_data),
    .fifo_ready_param_i (fifo_ready),
    .fifo_deq_i         (fifo_deq),
    .fifo_deq_id_i      (fifo_deq_id),
    .grant_id_o         (grant_id),
    .busy_o             (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // FIFO model: enqueue/dequeue decisions are latched at negedge, applied at posedge.
  always @(posedge clk) begin
    if (!reset_n) begin
      fifo_m.delete();
      for (int i = 0; i < N; i++) occ_m[i] = 0;
    end else begin
      if (pop_pend) begin
        occ_m[fifo_m[0][W +: IDW]]--;
        void'(fifo_m.pop_front());
      end
      if (push_pend) begin
        fifo_m.push_back(push_val);
        occ_m[push_val[W +: IDW]]++;
      end
    end
    count_m <= fifo_m.size();
    head_id <= (fifo_m.size() > 0) ? fifo_m[0][W +: IDW] : '0;
  end

  always @(negedge clk) begin
    push_pend = 1'b0;
    pop_pend  = 1'b0;
    acc_last  = reset_n ? (req_v & req_ready) : '0;
    if (reset_n) begin
      if (fifo_v) begin
        n_enq++;
        mon_id = fifo_data[W +: IDW];
        chk("grant_id", grant_id, mon_id);
        chk("req_ready_onehot", req_ready, onehot(mon_id));
        chk("v_implies_ready", fifo_ready, 1);
        if (rand_mode) begin
          chk("rand_data", fifo_data[W-1:0], req_data[mon_id]);
          chk("rand_req_valid", req_v[mon_id], 1);
          chk("rand_quota", occ_m[mon_id] < 2, 1);
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_enq: got id %0d data %0h required no enqueue", mon_id, fifo_data[W-1:0]);
        end else begin
          exp_e = exp_q.pop_front();
          chk("enq_busy_id_data", {busy, fifo_data}, exp_e);
        end
      end else begin
        chk("no_ready_without_v", req_ready, 0);
      end
      push_pend = fifo_v;
      push_val  = fifo_data;
      pop_pend  = fifo_deq;
    end
  end

  task automatic expect_beat(input int id, input logic b);
    exp_q.push_back({b, IDW'(id), req_data[id]});
  endtask

  task automatic set_data(input int t);
    for (int i = 0; i < N; i++) req_data[i] = W'((i + 1) * 4096 + t);
  endtask

  task automatic wait_enq(input int target, input int budget, input string name);
    int n = 0;
    while (n_enq < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n_enq < target) begin
      failures++;
      $display("FAIL %s: enqueues %0d required %0d", name, n_enq, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req_v   = '0;
    deq_en  = 1'b0;
    rdy_en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; n_enq = 0; count_m = 0; head_id = '0;
    rand_mode = 1'b0; push_pend = 1'b0; pop_pend = 1'b0; acc_last = '0;
    reset_n = 1'b0; rdy_en = 1'b1; deq_en = 1'b0; req_v = '0;
    set_data(1);

    // 1: everyone requests, FIFO never drains -> 0,0,1,1 then full
    req_v = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fifo_v", fifo_v, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_data", fifo_data, 0);
    @(posedge clk);
    #1;
    expect_beat(0, 0); expect_beat(0, 1); expect_beat(1, 0); expect_beat(1, 1);
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 4, 20, "t1_grants");
    repeat (3) begin
      @(negedge clk);
      chk("t1_full_stall", fifo_v, 0);
      chk("t1_idle_busy", busy, 0);
    end

    // 2: drain 0,0,1,1 one per cycle; quota-blocked 0/1 lose to 2,2 then 3,3
    @(posedge clk);
    #1;
    expect_beat(2, 0); expect_beat(2, 1); expect_beat(3, 0); expect_beat(3, 1);
    deq_en = 1'b1;
    wait_enq(base + 8, 30, "t2_grants");
    req_v = '0; deq_en = 1'b0;

    // 3: lone requester is re-granted after the pointer rotates past it
    do_reset();
    set_data(3);
    req_v = 4'b0100; deq_en = 1'b1;
    expect_beat(2, 0); expect_beat(2, 1); expect_beat(2, 0); expect_beat(2, 1);
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 4, 20, "t3_grants");
    req_v = '0; deq_en = 1'b0;

    // 4: burst owner drops after one beat -> one bubble, then requester 2
    do_reset();
    set_data(4);
    req_v = 4'b0110;
    expect_beat(1, 0); expect_beat(2, 0); expect_beat(2, 1);
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 1, 20, "t4_first");
    req_v = 4'b0100;
    @(negedge clk);
    chk("t4_bubble_v", fifo_v, 0);
    chk("t4_bubble_busy", busy, 1);
    wait_enq(base + 3, 20, "t4_after_bubble");
    req_v = '0;

    // 5: FIFO not ready mid-burst stalls without losing the burst
    do_reset();
    set_data(5);
    req_v = 4'b0001;
    expect_beat(0, 0); expect_beat(0, 1);
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 1, 20, "t5_first");
    rdy_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_stall_v", fifo_v, 0);
      chk("t5_stall_ready", req_ready, 0);
      chk("t5_stall_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    rdy_en = 1'b1;
    wait_enq(base + 2, 20, "t5_resume");
    @(negedge clk);
    chk("t5_quota_block", fifo_v, 0);
    chk("t5_quota_busy", busy, 0);
    @(posedge clk);
    #1;
    req_v = '0;

    // 6: reset inside the second burst clears lock, pointer and occupancy
    do_reset();
    set_data(6);
    req_v = 4'b1111;
    expect_beat(0, 0); expect_beat(0, 1); expect_beat(1, 0);
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 3, 20, "t6_pre");
    reset_n = 1'b0;
    #1;
    chk("t6_rst_v", fifo_v, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_data", fifo_data, 0);
    expect_beat(0, 0); expect_beat(0, 1); expect_beat(1, 0); expect_beat(1, 1);
    @(posedge clk);
    #1;
    base = n_enq;
    reset_n = 1'b1;
    wait_enq(base + 4, 20, "t6_post");
    @(negedge clk);
    chk("t6_full_stall", fifo_v, 0);
    @(posedge clk);
    #1;
    req_v = '0;

    // random: valid held until accepted, random deq and FIFO backpressure
    do_reset();
    rand_mode = 1'b1;
    base = n_enq;
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_last[i]) begin
          req_data[i] = W'($urandom);
          req_v[i]    = 1'($urandom_range(0, 1));
        end else if (!req_v[i]) begin
          req_v[i] = 1'($urandom_range(0, 1));
        end
      end
      rdy_en = ($urandom_range(0, 3) != 0);
      deq_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    req_v = '0; rdy_en = 1'b1; deq_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_progress", (n_enq - base) > 20, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
